// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Sequences LOAD/STORE/PUSH/POP requests onto a 256x8 synchronous
//            RAM, captures registered read data, and owns the stack pointer.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter logic [7:0] SP_RESET    = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'hC0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic       resp_err,
    output logic [7:0] resp_rdata,
    output logic [7:0] sp,
    output logic [7:0] mem_address,
    output logic       mem_write_enable,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_PUSH  = 3'b010;
    localparam logic [2:0] OP_POP   = 3'b011;

    // Stack is full once the pointer sits just below the lowest legal slot.
    localparam logic [7:0] SP_FULL  = STACK_LIMIT - 8'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CAP  = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic       stack_op, stack_op_nx;   // in-flight op adjusts sp on completion
    logic [7:0] sp_nx;
    logic [7:0] addr_nx;
    logic [7:0] wdata_nx;
    logic       we_nx;
    logic       rv_nx;
    logic       rerr_nx;
    logic [7:0] rdata_nx;

    assign req_ready = (state == IDLE);

    // State and all registered outputs; async reset forces write enable low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            stack_op         <= 1'b0;
            sp               <= SP_RESET;
            mem_address      <= 8'h00;
            mem_data_in      <= 8'h00;
            mem_write_enable <= 1'b0;
            resp_valid       <= 1'b0;
            resp_err         <= 1'b0;
            resp_rdata       <= 8'h00;
        end else begin
            state            <= state_nx;
            stack_op         <= stack_op_nx;
            sp               <= sp_nx;
            mem_address      <= addr_nx;
            mem_data_in      <= wdata_nx;
            mem_write_enable <= we_nx;
            resp_valid       <= rv_nx;
            resp_err         <= rerr_nx;
            resp_rdata       <= rdata_nx;
        end
    end

    // Next-state and next-output decode; address/data hold when not updated.
    always_comb begin
        state_nx    = state;
        stack_op_nx = stack_op;
        sp_nx       = sp;
        addr_nx     = mem_address;
        wdata_nx    = mem_data_in;
        we_nx       = 1'b0;
        rv_nx       = 1'b0;
        rerr_nx     = 1'b0;
        rdata_nx    = resp_rdata;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_LOAD: begin
                            addr_nx     = req_addr;
                            stack_op_nx = 1'b0;
                            state_nx    = RD;
                        end
                        OP_STORE: begin
                            addr_nx     = req_addr;
                            wdata_nx    = req_wdata;
                            we_nx       = 1'b1;
                            stack_op_nx = 1'b0;
                            state_nx    = WR;
                        end
                        OP_PUSH: begin
                            if (sp == SP_FULL) begin
                                rv_nx   = 1'b1;
                                rerr_nx = 1'b1;
                            end else begin
                                addr_nx     = sp;
                                wdata_nx    = req_wdata;
                                we_nx       = 1'b1;
                                stack_op_nx = 1'b1;
                                state_nx    = WR;
                            end
                        end
                        OP_POP: begin
                            if (sp == SP_RESET) begin
                                rv_nx   = 1'b1;
                                rerr_nx = 1'b1;
                            end else begin
                                addr_nx     = sp + 8'd1;
                                stack_op_nx = 1'b1;
                                state_nx    = RD;
                            end
                        end
                        default: begin
                            rv_nx   = 1'b1;
                            rerr_nx = 1'b1;
                        end
                    endcase
                end
            end
            WR: begin
                // RAM commits the write at this edge; acknowledge and retire.
                rv_nx    = 1'b1;
                state_nx = IDLE;
                if (stack_op) begin
                    sp_nx = sp - 8'd1;
                end
            end
            RD: begin
                // RAM registers the read data at this edge.
                state_nx = CAP;
            end
            CAP: begin
                rdata_nx = mem_data_out;
                rv_nx    = 1'b1;
                state_nx = IDLE;
                if (stack_op) begin
                    sp_nx = sp + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory access sequencer between the CPU execute stage and the 256x8 data RAM. Accepts LOAD/STORE/PUSH/POP requests over a valid/ready handshake and drives the RAM's address, write-enable and write-data ports. Captures the RAM's registered read data, which appears one clock after the address is presented. Owns the stack pointer and reports stack overflow, stack underflow and illegal opcodes as errors.

Parameters:
SP_RESET, 8'hFF, stack pointer value after reset; stack is empty when sp == SP_RESET
STACK_LIMIT, 8'hC0, lowest legal stack address; stack is full when sp == STACK_LIMIT-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (state IDLE)
req_op  input  3  000 LOAD, 001 STORE, 010 PUSH, 011 POP, 1xx illegal
req_addr  input  8  LOAD/STORE address; ignored for PUSH/POP
req_wdata  input  8  STORE/PUSH data
resp_valid  output  1  single-cycle completion pulse
resp_err  output  1  qualifies resp_valid; 1 = request rejected, no memory access
resp_rdata  output  8  LOAD/POP data; holds until the next successful LOAD/POP
sp  output  8  current stack pointer
mem_address  output  8  to RAM address
mem_write_enable  output  1  to RAM write enable
mem_data_in  output  8  to RAM write data
mem_data_out  input  8  from RAM; valid one cycle after the address is presented with write enable 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; sp=SP_RESET; all other outputs 0; mem_write_enable drops immediately.
- States: IDLE, WR, RD, CAP.
- Every mem_* output and resp_* output is registered.
- req_ready=1 only in IDLE. A request is accepted at the edge where req_valid && req_ready.
- Requests held during a busy cycle are ignored, not queued. req_* are sampled only at acceptance.
- Response has no backpressure. resp_valid is high for exactly one cycle per accepted request.
- Cycle numbering: acceptance edge E0 ends cycle 0; cycle 1 follows E0; edge E1 ends cycle 1; and so on.
- STORE: at E0, mem_address=req_addr, mem_data_in=req_wdata, mem_write_enable=1, state WR. In cycle 1 the RAM writes at E1. At E1: write enable cleared, resp_valid=1 for cycle 2, state IDLE, so req_ready=1 in cycle 2.
- PUSH:
  - Legal only if sp != STACK_LIMIT-1.
  - Behaves like STORE with mem_address=sp.
  - sp <= sp-1 at E1.
- LOAD: at E0, mem_address=req_addr, mem_write_enable=0, state RD. The RAM latches read data at E1; state CAP. At E2: resp_rdata<=mem_data_out, resp_valid=1 for cycle 3, state IDLE. Load latency is 3 cycles from acceptance to resp_valid.
- POP:
  - Legal only if sp != SP_RESET.
  - Behaves like LOAD with mem_address=sp+1 (8-bit).
  - sp <= sp+1 at E2.
- Errors (illegal op, PUSH when full, POP when empty): at E0, resp_valid=1 and resp_err=1 for cycle 1. No memory access, sp and resp_rdata unchanged, state remains IDLE.
- resp_err=0 on every successful response.
- Idle: mem_write_enable=0; mem_address and mem_data_in hold their last values. The RAM's idle reads are harmless.
- Back-to-back: a new request may be accepted in the same cycle that resp_valid is high.
- sp arithmetic is 8-bit modular. Full/empty checks prevent wrap when STACK_LIMIT <= SP_RESET.
- Reset mid-operation:
  - Reset during WR aborts the write if asserted before E1.
  - Reset during RD/CAP discards the read; no resp_valid is produced.
  - sp returns to SP_RESET.

Test Plan:
- STORE addr 8'h10 data 8'h5A, then LOAD 8'h10 -> store resp_valid in cycle 2, resp_err=0; load resp_valid in cycle 3 with resp_rdata=8'h5A; mem_write_enable high exactly one cycle.
- PUSH 8'h11, PUSH 8'h22, POP, POP -> RAM[FF]=11, RAM[FE]=22; sp goes FF→FE→FD→FE→FF; pops return 8'h22 then 8'h11.
- POP straight after reset -> resp_valid=1, resp_err=1 in cycle 1; sp stays 8'hFF; no mem_write_enable pulse; resp_rdata unchanged.
- 64 PUSHes (defaults), then a 65th -> first 64 succeed, sp=8'hBF; 65th returns resp_err=1; RAM[BF] untouched.
- req_op=3'b101, and req_valid held high throughout a LOAD -> illegal op gives a 1-cycle error response; during LOAD only one response occurs and req_ready=0 in cycles 1-2.
- rst_n pulsed low in cycle 1 of a STORE to 8'h20 (value 8'h77), then LOAD 8'h20 -> mem_write_enable falls asynchronously; no response; sp=8'hFF; RAM[20] keeps its prior value.
